// File: rtl/uart_tx_if.sv
// FIFO-to-transmitter link: head word and empty flag toward the transmitter,
// single-cycle pop strobe back toward the FIFO.
interface uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] idata;
  logic             empty;
  logic             next;

  modport master (output idata, output empty, input next);
  modport slave  (input idata, input empty, output next);
endinterface

// File: rtl/uart_tx.sv
// UART serializer: pops words from the upstream FIFO and sends start, data
// (LSB first), optional parity and stop bits, back-to-back while data is available.
module uart_tx #(
  parameter int WIDTH       = 8,
  parameter int CLK_PER_BIT = 868,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  uart_tx_if.slave fifo,
  output logic     txd,
  output logic     busy,
  output logic     done
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state_reg;
  logic [CW-1:0]    baud_reg;
  logic [BW-1:0]    bitcnt_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic             par_reg;
  logic             txd_reg;
  logic             next_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             baud_last;
  logic             stop_end;
  logic             load;
  logic             par_calc;
  logic [WIDTH-1:0] shreg_shift;

  assign baud_last   = (baud_reg == CW'(CLK_PER_BIT - 1));
  assign stop_end    = (state_reg == S_STOP) && baud_last && (bitcnt_reg == BW'(STOP_BITS - 1));
  // A new frame may start from idle or in the very last clk of the final stop bit.
  assign load        = en && !fifo.empty && ((state_reg == S_IDLE) || stop_end);
  assign par_calc    = (PARITY == 1) ? ~^fifo.idata : ^fifo.idata;
  assign shreg_shift = shreg_reg >> 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bitcnt_reg <= '0;
      shreg_reg  <= '0;
      par_reg    <= 1'b0;
      txd_reg    <= 1'b1;
      next_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      next_reg <= 1'b0;
      done_reg <= stop_end;
      if (load) begin
        state_reg  <= S_START;
        shreg_reg  <= fifo.idata;
        par_reg    <= par_calc;
        baud_reg   <= '0;
        bitcnt_reg <= '0;
        txd_reg    <= 1'b0;
        busy_reg   <= 1'b1;
        next_reg   <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: begin
            txd_reg  <= 1'b1;
            busy_reg <= 1'b0;
          end
          S_START: begin
            if (baud_last) begin
              baud_reg  <= '0;
              state_reg <= S_DATA;
              txd_reg   <= shreg_reg[0];
            end else begin
              baud_reg <= baud_reg + 1'b1;
            end
          end
          S_DATA: begin
            if (baud_last) begin
              baud_reg  <= '0;
              shreg_reg <= shreg_shift;
              if (bitcnt_reg == BW'(WIDTH - 1)) begin
                bitcnt_reg <= '0;
                if (PARITY != 0) begin
                  state_reg <= S_PARITY;
                  txd_reg   <= par_reg;
                end else begin
                  state_reg <= S_STOP;
                  txd_reg   <= 1'b1;
                end
              end else begin
                bitcnt_reg <= bitcnt_reg + 1'b1;
                txd_reg    <= shreg_shift[0];
              end
            end else begin
              baud_reg <= baud_reg + 1'b1;
            end
          end
          S_PARITY: begin
            if (baud_last) begin
              baud_reg  <= '0;
              state_reg <= S_STOP;
              txd_reg   <= 1'b1;
            end else begin
              baud_reg <= baud_reg + 1'b1;
            end
          end
          S_STOP: begin
            if (baud_last) begin
              baud_reg <= '0;
              if (stop_end) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
                txd_reg   <= 1'b1;
              end else begin
                bitcnt_reg <= bitcnt_reg + 1'b1;
              end
            end else begin
              baud_reg <= baud_reg + 1'b1;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign fifo.next = next_reg;
  assign txd       = txd_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Three transmitter configurations share one stimulus stream; each has its own
// FIFO model and a line decoder that checks every clk of every frame.
module tb_uart_tx;
  localparam int CPB  = 4;
  localparam int NCFG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            en;
  logic            push_req;
  logic [7:0]      push_data;
  logic [NCFG-1:0] txd_w;
  logic [NCFG-1:0] busy_w;
  logic [NCFG-1:0] done_w;
  logic [NCFG-1:0] next_w;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input int cfg,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cfg%0d: actual 'h%0h required 'h%0h at %0t", name, cfg, act, req, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g
    localparam int PAR   = (gi == 0) ? 0 : ((gi == 1) ? 2 : 1);
    localparam int STOPB = (gi == 2) ? 2 : 1;
    localparam int NB    = 1 + 8 + ((PAR != 0) ? 1 : 0) + STOPB;

    uart_tx_if #(.WIDTH(8)) fif ();
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    uart_tx #(
      .WIDTH(8), .CLK_PER_BIT(CPB), .PARITY(PAR), .STOP_BITS(STOPB)
    ) dut (
      .clk(clk), .rst(rst), .en(en), .fifo(fif),
      .txd(txd_w[gi]), .busy(busy_w[gi]), .done(done_w[gi])
    );
    assign next_w[gi] = fif.next;

    // Line image of one frame: start, data LSB first, parity, stop(s), idle-high fill.
    function automatic logic [15:0] frame_bits(input logic [7:0] w);
      logic [15:0] f;
      int ones;
      f = '1;
      ones = $countones(w);
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1 + i] = w[i];
      if (PAR == 1) f[9] = ((ones % 2) == 0);
      else if (PAR == 2) f[9] = ((ones % 2) == 1);
      return f;
    endfunction

    // FIFO model: pops on the single-clk next strobe, pushes on push_req.
    initial begin
      fif.idata = 8'h00;
      fif.empty = 1'b1;
      forever begin
        @(negedge clk);
        if (fif.next && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (push_req) begin
          fifo_q.push_back(push_data);
          exp_q.push_back(push_data);
        end
        fif.empty = (fifo_q.size() == 0);
        fif.idata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      end
    end

    // Monitor: decodes txd, pops the scoreboard at each start bit.
    initial begin
      bit have, prev_l, post, exp_reload, bad, aborted;
      logic [15:0] req, act;
      logic [7:0]  w;
      have = 0; prev_l = 0; post = 0;
      forever begin
        if (!have) begin @(negedge clk); #1; end
        have = 0;
        if (!rst) begin prev_l = 0; post = 0; continue; end
        chk((txd_w[gi] == 1'b0) == prev_l, "start", gi, {31'd0, ~txd_w[gi]}, {31'd0, prev_l});
        if (txd_w[gi]) begin
          if (!post)
            chk({busy_w[gi], next_w[gi], done_w[gi]} == 3'b000, "idle", gi,
                {busy_w[gi], next_w[gi], done_w[gi]}, 0);
          post = 0;
          prev_l = en && (fifo_q.size() != 0);
          continue;
        end
        post = 0;
        chk(exp_q.size() != 0, "exp_avail", gi, exp_q.size(), 1);
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        req = frame_bits(w);
        act = '1;
        bad = 0; aborted = 0; exp_reload = 0;
        for (int b = 0; b < NB && !aborted; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) begin @(negedge clk); #1; end
            if (!rst) begin aborted = 1; break; end
            if (c == CPB / 2) act[b] = txd_w[gi];
            if (txd_w[gi] != req[b] || !busy_w[gi] || next_w[gi] != (b == 0 && c == 0)) bad = 1;
            if ((b != 0 || c != 0) && done_w[gi]) bad = 1;
            if (b == NB - 1 && c == CPB - 1) exp_reload = en && (fifo_q.size() != 0);
          end
        end
        if (aborted) begin prev_l = 0; continue; end
        chk(!bad && act == req, "frame", gi, {15'd0, bad, act}, {16'd0, req});
        @(negedge clk); #1;
        if (!rst) begin prev_l = 0; continue; end
        chk(done_w[gi] == 1'b1, "done", gi, done_w[gi], 1);
        prev_l = exp_reload;
        have = 1;
        post = 1;
      end
    end
  end

  function automatic bit drained();
    return busy_w == '0 && g[0].fifo_q.size() == 0 && g[1].fifo_q.size() == 0
           && g[2].fifo_q.size() == 0;
  endfunction

  task automatic push_word(input logic [7:0] w);
    push_data = w;
    push_req  = 1'b1;
    @(posedge clk); #1;
    push_req  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!drained() && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(drained(), "drain", -1, n, budget);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; push_req = 1'b0; push_data = 8'h00;
    #1 rst = 1'b0;
    #2;
    for (int i = 0; i < NCFG; i++)
      chk({txd_w[i], next_w[i], busy_w[i], done_w[i]} == 4'b1000, "reset", i,
          {txd_w[i], next_w[i], busy_w[i], done_w[i]}, 4'b1000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Enabled but empty: the line must stay idle.
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk(txd_w == '1 && next_w == '0 && busy_w == '0, "idle_empty", -1,
        {txd_w, next_w, busy_w}, {3'b111, 3'b000, 3'b000});

    // Disabled with data waiting: no pop.
    en = 1'b0;
    push_word(8'hA5);
    repeat (20) @(posedge clk);
    #1;
    chk(busy_w == '0 && g[0].fifo_q.size() == 1, "disabled_no_pop", -1,
        {busy_w, 8'(g[0].fifo_q.size())}, {3'b000, 8'd1});
    en = 1'b1;
    wait_idle(200);

    // Parity pattern, then back-to-back frames.
    push_word(8'h03);
    wait_idle(200);
    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h55);
    wait_idle(400);

    // en dropped during frame 1 of 2: frame 2 stays queued.
    push_word(8'h3C);
    push_word(8'hC3);
    repeat (12) @(posedge clk);
    #1 en = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk(busy_w == '0 && g[0].fifo_q.size() == 1 && g[2].fifo_q.size() == 1, "en_drop", -1,
        {busy_w, 8'(g[0].fifo_q.size()), 8'(g[2].fifo_q.size())}, {3'b000, 8'd1, 8'd1});
    en = 1'b1;
    wait_idle(200);

    // Reset during data bit 3: line idles at once, interrupted word is lost.
    push_word(8'h96);
    push_word(8'h69);
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk(txd_w == '1 && busy_w == '0 && next_w == '0 && done_w == '0, "reset_async", -1,
        {txd_w, busy_w, next_w, done_w}, {3'b111, 9'd0});
    @(posedge clk);
    #1 rst = 1'b1;
    wait_idle(200);

    // Random words, gaps and enable toggling.
    for (int k = 0; k < 30; k++) begin
      en = ($urandom_range(0, 7) != 0);
      push_word(8'($urandom));
      repeat ($urandom_range(0, 50)) @(posedge clk);
      #1;
    end
    en = 1'b1;
    wait_idle(3000);

    chk(g[0].exp_q.size() == 0 && g[1].exp_q.size() == 0 && g[2].exp_q.size() == 0,
        "leftover", -1, g[0].exp_q.size() + g[1].exp_q.size() + g[2].exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
